dfd_cla_ones_count_sched: RTL and testbench

//  Time-shares one masked ones-count/compare datapath across NUM_CTX CLA trigger contexts.

---
 rtl/dfd_cla_pkg.sv | 16 +
 rtl/dfd_cla_ones_count_sched_if.sv | 30 +++
 rtl/dfd_cla_popcount_eq.sv | 21 ++
 rtl/dfd_cla_ones_count_sched.sv | 110 +++++++++++
 tb/tb_dfd_cla_ones_count_sched.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dfd_cla_pkg.sv
// rtl/dfd_cla_pkg.sv - CLA shared types and sizing for the ones-count scheduler
package dfd_cla_pkg;

  localparam int DEBUG_SIGNALS_WIDTH = 64;
  localparam int ONES_CNT_W          = $clog2(DEBUG_SIGNALS_WIDTH) + 1;
  localparam int ONES_NUM_CTX        = 4;
  localparam int ONES_HOLD_W         = 8;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    EVAL,
    PUBLISH
  } ones_sched_state_e;

endpackage

// File: rtl/dfd_cla_ones_count_sched_if.sv
// rtl/dfd_cla_ones_count_sched_if.sv - CSR-side and trigger-side signals of the ones-count scheduler
interface dfd_cla_ones_count_sched_if
  import dfd_cla_pkg::*;
#(
  parameter int DSW     = DEBUG_SIGNALS_WIDTH,
  parameter int NUM_CTX = ONES_NUM_CTX,
  parameter int HOLD_W  = ONES_HOLD_W,
  parameter int CNT_W   = ONES_CNT_W
);
  logic                            clear;
  logic                            en;
  logic [NUM_CTX-1:0]              ctx_en;
  logic [NUM_CTX-1:0][DSW-1:0]     ctx_mask;
  logic [NUM_CTX-1:0][CNT_W-1:0]   ctx_value;
  logic [NUM_CTX-1:0][HOLD_W-1:0]  ctx_hold;
  logic [DSW-1:0]                  debug_signals;
  logic [NUM_CTX-1:0]              ctx_match;
  logic                            match_valid;
  logic                            busy;

  modport master (
    output clear, en, ctx_en, ctx_mask, ctx_value, ctx_hold, debug_signals,
    input  ctx_match, match_valid, busy
  );

  modport slave (
    input  clear, en, ctx_en, ctx_mask, ctx_value, ctx_hold, debug_signals,
    output ctx_match, match_valid, busy
  );
endinterface

// File: rtl/dfd_cla_popcount_eq.sv
// rtl/dfd_cla_popcount_eq.sv - combinational masked ones-count compared against an expected value
module dfd_cla_popcount_eq #(
  parameter int DW = 64,
  parameter int CW = 7
) (
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] mask,
  input  logic [CW-1:0] value,
  output logic          eq
);
  logic [CW-1:0] ones;

  // CW holds 0..DW inclusive, so the sum never wraps
  always_comb begin
    ones = '0;
    for (int i = 0; i < DW; i++) begin
      ones = ones + CW'(data[i] & mask[i]);
    end
    eq = (ones == value);
  end
endmodule

// File: rtl/dfd_cla_ones_count_sched.sv
// rtl/dfd_cla_ones_count_sched.sv - one shared ones-count datapath time-sliced over NUM_CTX trigger contexts
module dfd_cla_ones_count_sched
  import dfd_cla_pkg::*;
#(
  parameter int DSW     = DEBUG_SIGNALS_WIDTH,
  parameter int NUM_CTX = ONES_NUM_CTX,
  parameter int HOLD_W  = ONES_HOLD_W,
  parameter int CNT_W   = $clog2(DSW) + 1
) (
  input logic                        clock,
  input logic                        reset,
  dfd_cla_ones_count_sched_if.slave  bus
);
  localparam int PTR_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  ones_sched_state_e               state_q, state_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [NUM_CTX-1:0]              en_snap_q;
  logic [DSW-1:0]                  snap_q;
  logic [NUM_CTX-1:0][HOLD_W-1:0]  cnt_q;
  logic [NUM_CTX-1:0]              ctx_match_q;
  logic [NUM_CTX-1:0]              above_mask;
  logic [NUM_CTX-1:0]              next_above;
  logic                            eval_eq;
  logic                            start_round;

  function automatic logic [PTR_W-1:0] lsb_idx(input logic [NUM_CTX-1:0] v);
    lsb_idx = '0;
    for (int i = NUM_CTX - 1; i >= 0; i--) begin
      if (v[i]) lsb_idx = PTR_W'(i);
    end
  endfunction

  dfd_cla_popcount_eq #(
    .DW (DSW),
    .CW (CNT_W)
  ) u_popcount_eq (
    .data  (snap_q),
    .mask  (bus.ctx_mask[ptr_q]),
    .value (bus.ctx_value[ptr_q]),
    .eq    (eval_eq)
  );

  // Contexts strictly above ptr; the shift wraps to zero when ptr is the top index
  assign above_mask  = ~((NUM_CTX'(2) << ptr_q) - NUM_CTX'(1));
  assign next_above  = en_snap_q & above_mask;
  assign start_round = bus.en && (|bus.ctx_en);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE:    if (start_round) state_d = CAPTURE;
      CAPTURE: begin
        state_d = EVAL;
        ptr_d   = lsb_idx(bus.ctx_en);
      end
      EVAL: begin
        if (|next_above) ptr_d = lsb_idx(next_above);
        else             state_d = PUBLISH;
      end
      PUBLISH: state_d = start_round ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      en_snap_q   <= '0;
      snap_q      <= '0;
      cnt_q       <= '0;
      ctx_match_q <= '0;
    end else if (bus.clear) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      en_snap_q   <= '0;
      snap_q      <= '0;
      cnt_q       <= '0;
      ctx_match_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == CAPTURE) begin
        snap_q    <= bus.debug_signals;
        en_snap_q <= bus.ctx_en;
      end
      // Guard keeps a round captured with no enabled context from touching ctx 0
      if (state_q == EVAL && en_snap_q[ptr_q]) begin
        if (!eval_eq)                cnt_q[ptr_q] <= '0;
        else if (cnt_q[ptr_q] != '1) cnt_q[ptr_q] <= cnt_q[ptr_q] + HOLD_W'(1);
      end
      if (state_q == PUBLISH) begin
        for (int i = 0; i < NUM_CTX; i++) begin
          if (en_snap_q[i]) begin
            ctx_match_q[i] <= (cnt_q[i] >= ((bus.ctx_hold[i] == '0) ? HOLD_W'(1) : bus.ctx_hold[i]));
          end else begin
            ctx_match_q[i] <= 1'b0;
            cnt_q[i]       <= '0;
          end
        end
      end
    end
  end

  assign bus.ctx_match   = ctx_match_q;
  assign bus.match_valid = (state_q == PUBLISH);
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_dfd_cla_ones_count_sched.sv
// tb/tb_dfd_cla_ones_count_sched.sv - directed bench with a round-level reference model
module tb_dfd_cla_ones_count_sched;
  localparam int NC = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   cmp_on = 1'b0;

  dfd_cla_ones_count_sched_if bus ();

  dfd_cla_ones_count_sched dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: a round is pending-capture, then k+1 edges later it publishes
  int          m_cnt [NC];
  logic [3:0]  m_match  = '0;
  logic [3:0]  m_ensnap = '0;
  logic [63:0] m_snap   = '0;
  bit          m_pend   = 1'b0;
  int          m_wait   = 0;

  always @(posedge clock or posedge reset) begin : model_b
    int   c [NC];
    logic [3:0] mt;
    bit   pend;
    int   w;
    int   hold_eff;
    bit   eq;
    if (reset || bus.clear) begin
      for (int i = 0; i < NC; i++) m_cnt[i] <= 0;
      m_match  <= '0;
      m_ensnap <= '0;
      m_snap   <= '0;
      m_pend   <= 1'b0;
      m_wait   <= 0;
    end else begin
      c    = m_cnt;
      mt   = m_match;
      pend = m_pend;
      w    = m_wait;
      if (pend) begin
        m_snap   <= bus.debug_signals;
        m_ensnap <= bus.ctx_en;
        w    = (($countones(bus.ctx_en) > 0) ? $countones(bus.ctx_en) : 1) + 1;
        pend = 1'b0;
      end else if (w > 0) begin
        w = w - 1;
        if (w == 0) begin
          for (int i = 0; i < NC; i++) begin
            if (m_ensnap[i]) begin
              eq = ($countones(m_snap & bus.ctx_mask[i]) == int'(bus.ctx_value[i]));
              c[i] = eq ? ((c[i] < 255) ? c[i] + 1 : 255) : 0;
              hold_eff = (bus.ctx_hold[i] == 0) ? 1 : int'(bus.ctx_hold[i]);
              mt[i] = (c[i] >= hold_eff);
            end else begin
              c[i]  = 0;
              mt[i] = 1'b0;
            end
          end
          pend = bus.en && (|bus.ctx_en);
        end
      end else begin
        pend = bus.en && (|bus.ctx_en);
      end
      m_cnt   <= c;
      m_match <= mt;
      m_pend  <= pend;
      m_wait  <= w;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_on) begin
      chk("model_match_valid", 64'(bus.match_valid), 64'(m_wait == 1));
      chk("model_ctx_match",   64'(bus.ctx_match),   64'(m_match));
      chk("model_busy",        64'(bus.busy),        64'(m_pend || (m_wait > 0)));
    end
  end

  task automatic wait_mv(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.match_valid && n < 50);
    if (!bus.match_valid) chk("wait_match_valid_timeout", 64'(0), 64'(1));
  endtask

  task automatic stop_round();
    bus.en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (!bus.busy) break;
    end
    chk("stop_idle", 64'(bus.busy), 64'(0));
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
  endtask

  task automatic set_ctx(input int i, input logic [63:0] mask, input int value, input int hold);
    bus.ctx_mask[i]  = mask;
    bus.ctx_value[i] = 7'(value);
    bus.ctx_hold[i]  = 8'(hold);
  endtask

  initial begin
    int n;
    int pulses;
    bus.clear = 1'b0;
    bus.en = 1'b0;
    bus.ctx_en = '0;
    bus.ctx_mask = '0;
    bus.ctx_value = '0;
    bus.ctx_hold = '0;
    bus.debug_signals = '0;
    repeat (3) @(negedge clock);
    chk("reset_ctx_match", 64'(bus.ctx_match), 64'(0));
    chk("reset_match_valid", 64'(bus.match_valid), 64'(0));
    chk("reset_busy", 64'(bus.busy), 64'(0));
    reset = 1'b0;
    cmp_on = 1'b1;

    // T1 single context
    set_ctx(0, 64'hFF, 3, 0);
    bus.debug_signals = 64'h07;
    bus.ctx_en = 4'b0001;
    bus.en = 1'b1;
    wait_mv(n);
    chk("t1_latency", 64'(n), 64'(3));
    @(negedge clock);
    chk("t1_ctx_match", 64'(bus.ctx_match), 64'(4'b0001));
    stop_round();

    // T2 hold of 3 consecutive rounds
    set_ctx(0, 64'hFF, 3, 3);
    bus.en = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      wait_mv(n);
      @(negedge clock);
      chk("t2_hold_match", 64'(bus.ctx_match[0]), 64'(r >= 3));
    end
    stop_round();

    // T3 sparse contexts 1 and 3
    set_ctx(0, 64'hFF, 3, 0);
    set_ctx(1, 64'hFF, 3, 0);
    set_ctx(2, 64'h07, 3, 0);
    set_ctx(3, 64'hF0, 0, 0);
    bus.ctx_en = 4'b1010;
    bus.en = 1'b1;
    wait_mv(n);
    chk("t3_first_latency", 64'(n), 64'(4));
    wait_mv(n);
    chk("t3_round_period", 64'(n), 64'(4));
    @(negedge clock);
    chk("t3_ctx_match", 64'(bus.ctx_match), 64'(4'b1010));
    stop_round();

    // T4 mismatch breaks the streak
    set_ctx(0, 64'hFF, 3, 2);
    bus.ctx_en = 4'b0001;
    bus.en = 1'b1;
    wait_mv(n);
    @(negedge clock);
    chk("t4_p1", 64'(bus.ctx_match[0]), 64'(0));
    wait_mv(n);
    bus.debug_signals = 64'h0F;
    @(negedge clock);
    chk("t4_p2", 64'(bus.ctx_match[0]), 64'(1));
    @(negedge clock);
    bus.debug_signals = 64'h07;
    wait_mv(n);
    @(negedge clock);
    chk("t4_p3_break", 64'(bus.ctx_match[0]), 64'(0));
    wait_mv(n);
    @(negedge clock);
    chk("t4_p4", 64'(bus.ctx_match[0]), 64'(0));
    wait_mv(n);
    @(negedge clock);
    chk("t4_p5_reassert", 64'(bus.ctx_match[0]), 64'(1));
    stop_round();

    // T5 count boundaries
    bus.debug_signals = '1;
    set_ctx(0, '1, 64, 0);
    set_ctx(1, '0, 0, 0);
    set_ctx(2, '1, 63, 0);
    set_ctx(3, '1, 65, 0);
    bus.ctx_en = 4'b1111;
    bus.en = 1'b1;
    wait_mv(n);
    chk("t5_latency", 64'(n), 64'(6));
    @(negedge clock);
    chk("t5_ctx_match", 64'(bus.ctx_match), 64'(4'b0011));

    // T6 async reset during EVAL
    wait_mv(n);
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_ctx_match", 64'(bus.ctx_match), 64'(0));
    chk("t6_rst_match_valid", 64'(bus.match_valid), 64'(0));
    chk("t6_rst_busy", 64'(bus.busy), 64'(0));
    bus.en = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // T6 sync clear during EVAL
    bus.en = 1'b1;
    wait_mv(n);
    @(negedge clock);
    @(negedge clock);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    chk("t6_clr_ctx_match", 64'(bus.ctx_match), 64'(0));
    chk("t6_clr_match_valid", 64'(bus.match_valid), 64'(0));
    chk("t6_clr_busy", 64'(bus.busy), 64'(0));

    // T6 en dropped mid-round
    wait_mv(n);
    @(negedge clock);
    @(negedge clock);
    bus.en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.match_valid) pulses++;
      if (!bus.busy) break;
    end
    chk("t6_en_drop_pulses", 64'(pulses), 64'(1));
    chk("t6_en_drop_idle", 64'(bus.busy), 64'(0));

    // No enabled context keeps the scheduler idle
    bus.ctx_en = '0;
    bus.en = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_no_ctx", 64'(bus.busy), 64'(0));
    bus.en = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
